// File: rtl/mem_copy_host.sv
// mem_copy_host: word-granular memory-to-memory copy engine on a single host bus.
//
// A copy is a loop of one read followed by one write per 32-bit word. At most one bus
// transaction is outstanding at any time.
//
// Control ports:
//   start_i     single-cycle request, sampled only while idle
//   src_addr_i  source byte address; the low two bits are dropped
//   dst_addr_i  destination byte address; the low two bits are dropped
//   len_i       number of words to copy
//   busy_o      high while a copy is running
//   done_o      one-cycle pulse on completion or abort
//   err_o       sticky error flag for the last copy
//   count_o     number of words fully copied so far
//
// Host bus ports (request/grant, then a response on rvalid):
//   host_req_o, host_gnt_i, host_addr_o, host_we_o, host_be_o, host_wdata_o
//   host_rvalid_i, host_rdata_i, host_err_i
module mem_copy_host #(
    parameter int unsigned LenWidth = 16
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [LenWidth-1:0] len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [LenWidth-1:0] count_o,
    output logic                host_req_o,
    input  logic                host_gnt_i,
    output logic [31:0]         host_addr_o,
    output logic                host_we_o,
    output logic [3:0]          host_be_o,
    output logic [31:0]         host_wdata_o,
    input  logic                host_rvalid_i,
    input  logic [31:0]         host_rdata_i,
    input  logic                host_err_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrReq,
        StWrWait
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] count_q, count_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic [31:0]         word_off;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    if (len_i != '0) begin
                        src_d   = {src_addr_i[31:2], 2'b00};
                        dst_d   = {dst_addr_i[31:2], 2'b00};
                        len_d   = len_i;
                        state_d = StRdReq;
                    end else begin
                        // Zero-length copy completes immediately without touching the bus.
                        done_d = 1'b1;
                    end
                end
            end
            StRdReq: begin
                if (host_gnt_i) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (host_rvalid_i) begin
                    if (host_err_i) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        rdata_d = host_rdata_i;
                        state_d = StWrReq;
                    end
                end
            end
            StWrReq: begin
                if (host_gnt_i) begin
                    state_d = StWrWait;
                end
            end
            StWrWait: begin
                if (host_rvalid_i) begin
                    if (host_err_i) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        count_d = count_q + LenWidth'(1);
                        if (count_d == len_q) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StRdReq;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Byte offset of the current word; wraps modulo 2^32 when added to the base.
    assign word_off = 32'(count_q) << 2;

    // Bus outputs decode straight from the state register, so an asynchronous reset drops
    // the request in the same cycle.
    always_comb begin
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_be_o    = 4'h0;
        host_addr_o  = 32'h0;
        host_wdata_o = 32'h0;
        if (state_q == StRdReq) begin
            host_req_o  = 1'b1;
            host_be_o   = 4'hF;
            host_addr_o = src_q + word_off;
        end else if (state_q == StWrReq) begin
            host_req_o   = 1'b1;
            host_we_o    = 1'b1;
            host_be_o    = 4'hF;
            host_addr_o  = dst_q + word_off;
            host_wdata_o = rdata_q;
        end
    end

    assign busy_o  = (state_q != StIdle);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign count_o = count_q;

endmodule
